// File: rtl/gecko_reg_scoreboard_if.sv
// Decode <-> register scoreboard bus: issue/writeback notifications,
// operand queries and the availability answers returned to decode.
interface gecko_reg_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic       issue_forwardable;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic [4:0] query_rs1;
  logic [4:0] query_rs2;
  logic [4:0] query_rd;
  logic [4:0] execute_saved_reg;
  logic       rs1_ready;
  logic       rs2_ready;
  logic       rd_ready;
  logic       error;

  modport master (
    output issue_valid, issue_rd, issue_forwardable, wb_valid, wb_rd,
           query_rs1, query_rs2, query_rd,
    input  execute_saved_reg, rs1_ready, rs2_ready, rd_ready, error
  );

  modport slave (
    input  issue_valid, issue_rd, issue_forwardable, wb_valid, wb_rd,
           query_rs1, query_rs2, query_rd,
    output execute_saved_reg, rs1_ready, rs2_ready, rd_ready, error
  );
endinterface

// File: rtl/gecko_reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters with saturating
// protocol checks, execute-forwarding tracking and zero-cycle operand lookup.
package gecko_reg_scoreboard_pkg;
  typedef enum logic [1:0] {
    GECKO_REG_STATUS_VALID   = 2'd0,
    GECKO_REG_STATUS_PENDING = 2'd1,
    GECKO_REG_STATUS_FULL    = 2'd2
  } gecko_reg_status_t;
endpackage

module gecko_reg_scoreboard
  import gecko_reg_scoreboard_pkg::*;
#(
  parameter int COUNTER_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  gecko_reg_scoreboard_if.slave    sb,
  output gecko_reg_status_t        reg_status [32]
);

  localparam int NUM_REGS = 32;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1'b1);

  logic [COUNTER_WIDTH-1:0] cnt_r      [1:NUM_REGS-1];
  logic [COUNTER_WIDTH-1:0] cnt_next_s [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]      issue_hit_s;
  logic [NUM_REGS-1:1]      wb_hit_s;
  logic                     drop_s;
  logic [4:0]               saved_r;
  logic [4:0]               saved_next_s;
  logic                     error_r;
  gecko_reg_status_t        status_s [NUM_REGS];

  function automatic gecko_reg_status_t status_of(input logic [COUNTER_WIDTH-1:0] c);
    if (c == CNT_ZERO) begin
      return GECKO_REG_STATUS_VALID;
    end else if (c == CNT_MAX) begin
      return GECKO_REG_STATUS_FULL;
    end else begin
      return GECKO_REG_STATUS_PENDING;
    end
  endfunction

  // Decode which register (x1..x31) the issue and writeback ports address.
  always_comb begin
    issue_hit_s = '0;
    wb_hit_s    = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      issue_hit_s[i] = sb.issue_valid && (sb.issue_rd == 5'(i));
      wb_hit_s[i]    = sb.wb_valid && (sb.wb_rd == 5'(i));
    end
  end

  // Next counter values; overflowing issues and underflowing writebacks are dropped and flagged.
  always_comb begin
    cnt_next_s = cnt_r;
    drop_s     = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (issue_hit_s[i] && wb_hit_s[i]) begin
        cnt_next_s[i] = cnt_r[i];
      end else if (issue_hit_s[i]) begin
        if (cnt_r[i] == CNT_MAX) begin
          drop_s = 1'b1;
        end else begin
          cnt_next_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else if (wb_hit_s[i]) begin
        if (cnt_r[i] == CNT_ZERO) begin
          drop_s = 1'b1;
        end else begin
          cnt_next_s[i] = cnt_r[i] - CNT_ONE;
        end
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
  end

  // Execute holds the value of the last issued forwardable op; any other issue invalidates it.
  always_comb begin
    saved_next_s = saved_r;
    if (sb.issue_valid) begin
      if (sb.issue_forwardable) begin
        saved_next_s = sb.issue_rd;
      end else begin
        saved_next_s = 5'd0;
      end
    end else begin
      saved_next_s = saved_r;
    end
  end

  // State registers with synchronous reset; the error flag is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      saved_r <= 5'd0;
      error_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_next_s;
      saved_r <= saved_next_s;
      error_r <= error_r | drop_s;
    end
  end

  // Status decode straight from the registered counters; x0 is hardwired valid.
  always_comb begin
    status_s[0] = GECKO_REG_STATUS_VALID;
    for (int i = 1; i < NUM_REGS; i++) begin
      status_s[i] = status_of(cnt_r[i]);
    end
  end

  assign reg_status           = status_s;
  assign sb.execute_saved_reg = saved_r;
  assign sb.error             = error_r;

  // Lookups see only registered state, never the same-cycle issue/writeback.
  assign sb.rs1_ready = (sb.query_rs1 == 5'd0) || (sb.query_rs1 == saved_r) ||
                        (status_s[sb.query_rs1] == GECKO_REG_STATUS_VALID);
  assign sb.rs2_ready = (sb.query_rs2 == 5'd0) || (sb.query_rs2 == saved_r) ||
                        (status_s[sb.query_rs2] == GECKO_REG_STATUS_VALID);
  assign sb.rd_ready  = (sb.query_rd == 5'd0) ||
                        (status_s[sb.query_rd] != GECKO_REG_STATUS_FULL);

endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// Directed bench for gecko_reg_scoreboard: a reference model predicts status,
// forwarding register and error flag, queued at drive time and checked after the edge.
module tb_gecko_reg_scoreboard;
  import gecko_reg_scoreboard_pkg::*;

  localparam int MAX = 3;

  typedef struct {
    int                idx;
    gecko_reg_status_t st;
    logic [4:0]        saved;
    logic              err;
  } exp_t;

  logic              clk;
  logic              rst;
  gecko_reg_status_t reg_status [32];
  gecko_reg_scoreboard_if sb_if ();

  gecko_reg_scoreboard #(.COUNTER_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sb         (sb_if.slave),
    .reg_status (reg_status)
  );

  int         checks = 0;
  int         errors = 0;
  int         m_cnt [32];
  logic [4:0] m_saved;
  logic       m_err;
  exp_t       exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic gecko_reg_status_t model_status(input int idx);
    if (idx == 0 || m_cnt[idx] == 0) return GECKO_REG_STATUS_VALID;
    if (m_cnt[idx] == MAX) return GECKO_REG_STATUS_FULL;
    return GECKO_REG_STATUS_PENDING;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int idx);
    exp_t e;
    e.idx   = idx;
    e.st    = model_status(idx);
    e.saved = m_saved;
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: update model, queue expectations, clock, then drain the queue.
  task automatic step(input logic iv, input logic [4:0] ird, input logic fwd,
                      input logic wv, input logic [4:0] wrd, input logic r);
    exp_t e;
    sb_if.issue_valid       = iv;
    sb_if.issue_rd          = ird;
    sb_if.issue_forwardable = fwd;
    sb_if.wb_valid          = wv;
    sb_if.wb_rd             = wrd;
    rst                     = r;
    if (r) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_saved = 5'd0;
      m_err   = 1'b0;
      for (int i = 0; i < 32; i++) push_exp(i);
    end else begin
      if (iv) m_saved = fwd ? ird : 5'd0;
      if (!(iv && wv && ird == wrd && ird != 5'd0)) begin
        if (iv && ird != 5'd0) begin
          if (m_cnt[ird] == MAX) m_err = 1'b1;
          else m_cnt[ird]++;
        end
        if (wv && wrd != 5'd0) begin
          if (m_cnt[wrd] == 0) m_err = 1'b1;
          else m_cnt[wrd]--;
        end
      end
      push_exp(int'(ird));
      push_exp(int'(wrd));
    end
    @(posedge clk);
    #1;
    sb_if.issue_valid = 1'b0;
    sb_if.wb_valid    = 1'b0;
    rst               = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("status[%0d]", e.idx), 32'(reg_status[e.idx]), 32'(e.st));
      chk("execute_saved_reg", 32'(sb_if.execute_saved_reg), 32'(e.saved));
      chk("error", 32'(sb_if.error), 32'(e.err));
    end
  endtask

  // Zero-cycle operand lookup against the model's current state.
  task automatic check_ready(input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] qd);
    logic e1, e2, ed;
    sb_if.query_rs1 = q1;
    sb_if.query_rs2 = q2;
    sb_if.query_rd  = qd;
    #1;
    e1 = (q1 == 5'd0) || (q1 == m_saved) || (m_cnt[q1] == 0);
    e2 = (q2 == 5'd0) || (q2 == m_saved) || (m_cnt[q2] == 0);
    ed = (qd == 5'd0) || (m_cnt[qd] != MAX);
    chk($sformatf("rs1_ready(x%0d)", q1), 32'(sb_if.rs1_ready), 32'(e1));
    chk($sformatf("rs2_ready(x%0d)", q2), 32'(sb_if.rs2_ready), 32'(e2));
    chk($sformatf("rd_ready(x%0d)", qd), 32'(sb_if.rd_ready), 32'(ed));
  endtask

  initial begin
    sb_if.issue_valid       = 1'b0;
    sb_if.issue_rd          = 5'd0;
    sb_if.issue_forwardable = 1'b0;
    sb_if.wb_valid          = 1'b0;
    sb_if.wb_rd             = 5'd0;
    sb_if.query_rs1         = 5'd0;
    sb_if.query_rs2         = 5'd0;
    sb_if.query_rd          = 5'd0;
    rst                     = 1'b1;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_saved = 5'd0;
    m_err   = 1'b0;

    // Reset state
    step(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1);
    check_ready(5'd5, 5'd31, 5'd7);
    check_ready(5'd0, 5'd1, 5'd0);

    // Non-forwardable then forwardable issue to x5
    step(1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0);
    check_ready(5'd5, 5'd6, 5'd5);
    step(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    check_ready(5'd5, 5'd5, 5'd5);

    // Fill x7 to MAX, then overflow with a forwardable issue
    step(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
    check_ready(5'd7, 5'd5, 5'd7);
    step(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    check_ready(5'd7, 5'd5, 5'd7);

    // Same-register issue+wb at MAX leaves count; clear error first
    step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    step(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0);

    // Same-register issue+wb at count 1 and at count 0
    step(1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    step(1'b1, 5'd11, 1'b1, 1'b1, 5'd11, 1'b0);

    // x0 traffic is ignored
    step(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    check_ready(5'd0, 5'd9, 5'd0);

    // Independent issue and wb on different registers
    step(1'b1, 5'd10, 1'b1, 1'b1, 5'd7, 1'b0);
    check_ready(5'd10, 5'd7, 5'd7);

    // Writeback underflow, error stays sticky
    step(1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0);
    step(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
    check_ready(5'd3, 5'd4, 5'd12);

    // Reset mid-operation discards everything, including that cycle's issue
    step(1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1);
    check_ready(5'd3, 5'd4, 5'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
